// File: rtl/irobot_motion_pkg.sv
// Shared motion-control definitions: state encodings, angle command fields,
// move-type mux codes and default speed constants.
package irobot_motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPIN  = 2'd1,
    ST_DRIVE = 2'd2
  } move_state_e;

  typedef enum logic [1:0] {
    MUX_PAUSE  = 2'd0,
    MUX_SPIRAL = 2'd1,
    MUX_RAND   = 2'd2
  } move_mux_e;

  // angle_cmd field positions
  localparam int ANG_CW   = 9;
  localparam int ANG_SPIN = 8;
  localparam int ANG_MSB  = 7;
  localparam int ANG_LSB  = 0;

  localparam int DEF_VEL_WIDTH      = 16;
  localparam int DEF_DRIVE_SPEED    = 200;
  localparam int DEF_SPIN_SPEED     = 100;
  localparam int DEF_TICKS_PER_UNIT = 1024;
  localparam int DEF_CNT_WIDTH      = 24;

  // A spin only happens when it is requested and the angle is non-zero.
  function automatic logic spin_requested(input logic [9:0] cmd);
    return cmd[ANG_SPIN] && (cmd[ANG_MSB:ANG_LSB] != 8'd0);
  endfunction

endpackage

// File: rtl/spin_timer.sv
// Loadable down-counter that flags the last cycle of a timed spin.
module spin_timer #(
  parameter int CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 expire
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  // Count 1 is the final spin cycle; the owner moves on at the next edge.
  assign expire = (count == CNT_WIDTH'(1));

endmodule

// File: rtl/random_move_gen.sv
// Turns a random-move request into a timed in-place spin followed by a
// straight forward drive, held until the request is withdrawn.
module random_move_gen
  import irobot_motion_pkg::*;
#(
  parameter int VEL_WIDTH      = DEF_VEL_WIDTH,
  parameter int DRIVE_SPEED    = DEF_DRIVE_SPEED,
  parameter int SPIN_SPEED     = DEF_SPIN_SPEED,
  parameter int TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        random_enable,
  input  logic [9:0]                  angle_cmd,
  output logic signed [VEL_WIDTH-1:0] left_vel,
  output logic signed [VEL_WIDTH-1:0] right_vel,
  output logic                        spin_active,
  output logic                        spin_done,
  output logic                        busy
);

  if (CNT_WIDTH < 8 + $clog2(TICKS_PER_UNIT)) begin : g_cnt_width_check
    $error("random_move_gen: CNT_WIDTH too small for 8-bit angle times TICKS_PER_UNIT");
  end
  if (SPIN_SPEED >= (1 << (VEL_WIDTH - 1)) || DRIVE_SPEED >= (1 << (VEL_WIDTH - 1))) begin : g_speed_check
    $error("random_move_gen: speed constant does not fit signed VEL_WIDTH");
  end

  localparam logic signed [VEL_WIDTH-1:0] SPIN_POS  = VEL_WIDTH'(SPIN_SPEED);
  localparam logic signed [VEL_WIDTH-1:0] SPIN_NEG  = -SPIN_POS;
  localparam logic signed [VEL_WIDTH-1:0] DRIVE_VEL = VEL_WIDTH'(DRIVE_SPEED);

  move_state_e          state_reg;
  logic                 en_q;
  logic                 cw_q;
  logic                 start;
  logic                 stop;
  logic                 spin_req;
  logic [CNT_WIDTH-1:0] load_value;
  logic [CNT_WIDTH-1:0] count;
  logic                 expire;

  assign start    = random_enable & ~en_q;
  assign stop     = ~random_enable;
  assign spin_req = spin_requested(angle_cmd);

  // Every start reloads the timer; a no-spin start loads zero so any
  // abandoned spin is wiped.
  always_comb begin
    load_value = '0;
    if (spin_req) begin
      load_value = CNT_WIDTH'(angle_cmd[ANG_MSB:ANG_LSB]) * CNT_WIDTH'(TICKS_PER_UNIT);
    end
  end

  spin_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_spin_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .clear      (stop),
    .load_value (load_value),
    .count      (count),
    .expire     (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      en_q        <= 1'b0;
      cw_q        <= 1'b0;
      left_vel    <= '0;
      right_vel   <= '0;
      spin_active <= 1'b0;
      spin_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      en_q      <= random_enable;
      spin_done <= 1'b0;
      if (stop) begin
        state_reg   <= ST_IDLE;
        left_vel    <= '0;
        right_vel   <= '0;
        spin_active <= 1'b0;
        busy        <= 1'b0;
      end else if (start) begin
        // A fresh start wins over any pending SPIN->DRIVE transition.
        cw_q <= angle_cmd[ANG_CW];
        busy <= 1'b1;
        if (spin_req) begin
          state_reg   <= ST_SPIN;
          spin_active <= 1'b1;
          left_vel    <= angle_cmd[ANG_CW] ? SPIN_POS : SPIN_NEG;
          right_vel   <= angle_cmd[ANG_CW] ? SPIN_NEG : SPIN_POS;
        end else begin
          state_reg   <= ST_DRIVE;
          spin_active <= 1'b0;
          left_vel    <= DRIVE_VEL;
          right_vel   <= DRIVE_VEL;
        end
      end else begin
        unique case (state_reg)
          ST_SPIN: begin
            if (expire) begin
              state_reg   <= ST_DRIVE;
              spin_active <= 1'b0;
              spin_done   <= 1'b1;
              left_vel    <= DRIVE_VEL;
              right_vel   <= DRIVE_VEL;
            end else begin
              left_vel  <= cw_q ? SPIN_POS : SPIN_NEG;
              right_vel <= cw_q ? SPIN_NEG : SPIN_POS;
            end
          end
          ST_DRIVE: begin
            left_vel  <= DRIVE_VEL;
            right_vel <= DRIVE_VEL;
          end
          default: begin
            state_reg   <= ST_IDLE;
            left_vel    <= '0;
            right_vel   <= '0;
            spin_active <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_move_gen.sv
// Self-checking bench for random_move_gen: directed scenarios then random
// request traffic, compared every cycle against a timeline-based model.
module tb_random_move_gen;
  import irobot_motion_pkg::*;

  localparam int VW = 16;
  localparam int TK = 4;
  localparam int SS = 100;
  localparam int DS = 200;
  localparam int CW = 24;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 random_enable = 1'b0;
  logic [9:0]           angle_cmd = '0;
  logic signed [VW-1:0] left_vel;
  logic signed [VW-1:0] right_vel;
  logic                 spin_active;
  logic                 spin_done;
  logic                 busy;

  random_move_gen #(
    .VEL_WIDTH      (VW),
    .DRIVE_SPEED    (DS),
    .SPIN_SPEED     (SS),
    .TICKS_PER_UNIT (TK),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .random_enable (random_enable),
    .angle_cmd     (angle_cmd),
    .left_vel      (left_vel),
    .right_vel     (right_vel),
    .spin_active   (spin_active),
    .spin_done     (spin_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string phase = "reset";

  // Model: a request is a timeline; k counts cycles since its start edge.
  bit m_active = 0;
  bit m_prev_en = 0;
  bit m_cw = 0;
  int m_k = 0;
  int m_spin_cycles = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic step();
    int e_l, e_r, e_sa, e_sd, e_b;
    @(posedge clk);
    if (rst) begin
      m_active  = 0;
      m_prev_en = 0;
    end else begin
      if (!random_enable) begin
        m_active = 0;
      end else if (!m_prev_en) begin
        m_active      = 1;
        m_k           = 0;
        m_cw          = angle_cmd[9];
        m_spin_cycles = (angle_cmd[8] == 1'b1) ? int'(angle_cmd[7:0]) * TK : 0;
      end else if (m_active) begin
        m_k++;
      end
      m_prev_en = random_enable;
    end
    #1;
    e_l = 0; e_r = 0; e_sa = 0; e_sd = 0; e_b = 0;
    if (m_active) begin
      e_b = 1;
      if (m_k < m_spin_cycles) begin
        e_sa = 1;
        e_l  = m_cw ? SS : -SS;
        e_r  = m_cw ? -SS : SS;
      end else begin
        e_l  = DS;
        e_r  = DS;
        e_sd = (m_spin_cycles > 0 && m_k == m_spin_cycles) ? 1 : 0;
      end
    end
    check("left_vel", $signed(left_vel), e_l);
    check("right_vel", $signed(right_vel), e_r);
    check("spin_active", spin_active, e_sa);
    check("spin_done", spin_done, e_sd);
    check("busy", busy, e_b);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int spin_cnt;
    int done_cnt;
    logic [1:0] hi;
    logic [7:0] ang;

    rst = 1'b1;
    run(2);
    rst = 1'b0;
    phase = "idle";
    run(20);

    phase = "cw3";
    angle_cmd = 10'b11_00000011;
    random_enable = 1'b1;
    spin_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (spin_active === 1'b1) spin_cnt++;
      if (spin_done === 1'b1) done_cnt++;
      angle_cmd = 10'($urandom_range(0, 1023));
    end
    check("spin_cycles", spin_cnt, 12);
    check("done_pulses", done_cnt, 1);
    random_enable = 1'b0;
    run(2);

    phase = "ccw2";
    angle_cmd = 10'b01_00000010;
    random_enable = 1'b1;
    run(12);
    random_enable = 1'b0;
    run(2);

    phase = "nospin";
    angle_cmd = 10'b00_00000101;
    random_enable = 1'b1;
    run(4);
    random_enable = 1'b0;
    run(1);

    phase = "zero_angle";
    angle_cmd = 10'b11_00000000;
    random_enable = 1'b1;
    run(4);
    random_enable = 1'b0;
    run(1);

    phase = "restart";
    angle_cmd = 10'b11_00000011;
    random_enable = 1'b1;
    run(5);
    random_enable = 1'b0;
    run(1);
    angle_cmd = 10'b11_00000001;
    random_enable = 1'b1;
    run(8);

    phase = "rst_in_drive";
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    angle_cmd = 10'b01_00000001;
    run(10);
    random_enable = 1'b0;
    run(2);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if (random_enable) begin
        if ($urandom_range(0, 11) == 0) random_enable = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        random_enable = 1'b1;
      end
      hi  = 2'($urandom_range(0, 3));
      ang = 8'($urandom_range(0, 4));
      angle_cmd = {hi, ang};
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
